stack_seq: RTL and testbench
============================

// Module: stack_seq
// PURPOSE
//  Stack access sequencer for the data-memory stack. Accepts PUSH/POP commands of 16- or 32-bit
//  payloads from the execute stage, owns the stack pointer (full-descending, reset to all ones),
//  and drives the single-port 16-bit data memory one word per cycle. Reports completion, popped
//  data and overflow/underflow to the pipeline; the pipeline stalls while cmd_ready is low.
// PARAMETERS
//  ADDR_W   10   data-memory address width; stack capacity = 2**ADDR_W words
//  DATA_W   16   memory word width; 32-bit payloads are two words
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst          in   1         asynchronous, active-low reset
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         high only in IDLE; command accepted when valid && ready
//  cmd_op       in   2         00 PUSH16, 01 POP16, 10 PUSH32, 11 POP32
//  cmd_wdata    in   2*DATA_W  push payload; PUSH16 uses [DATA_W-1:0] only
//  rsp_valid    out  1         one-cycle completion pulse per accepted command
//  rsp_err      out  1         valid with rsp_valid; command rejected (over/underflow)
//  rsp_rdata    out  2*DATA_W  pop result; POP16 zero-extends; held until next POP completion
//  mem_addr     out  ADDR_W    data-memory address
//  mem_we       out  1         write strobe
//  mem_re       out  1         read strobe; memory returns mem_rdata the following cycle
//  mem_wdata    out  DATA_W    write data
//  mem_rdata    in   DATA_W    read data (1-cycle latency)
//  sp           out  ADDR_W    stack pointer = address of next free slot
//  empty/full   out  1 each    depth==0 / depth==2**ADDR_W
//  ovf/unf      out  1 each    sticky overflow / underflow flags
//  err_clr      in   1         clears ovf/unf
// BEHAVIOUR
//  Reset: sp=all ones, depth(ADDR_W+1 bits)=0, state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0,
//   ovf=unf=0, mem_we=mem_re=0. Reset mid-sequence aborts; words already written stay in memory.
//  FSM: IDLE, WR_HI, WR_LO, RD_LO, RD_HI, CAP, DONE. mem_we only in WR_*, mem_re only in RD_*.
//  PUSH: write mem[sp], sp<=sp-1, depth<=depth+1 per word. PUSH32: WR_HI writes cmd_wdata[hi],
//   WR_LO writes [lo] (low half at lower address). PUSH16: WR_LO only. Payload latched on accept.
//  POP: sp<=sp+1, depth<=depth-1, read mem[sp+1] per word. POP16: RD_LO, CAP, DONE.
//   POP32: RD_LO, RD_HI (latch lo), CAP (latch hi), DONE; rsp_rdata={hi,lo}.
//  Latency accept-edge -> rsp_valid: PUSH16 2, PUSH32 3, POP16 3, POP32 4 cycles. DONE lasts 1
//   cycle then IDLE; back-to-back commands therefore spaced by latency+1.
//  Checks at accept: PUSH of n words with depth+n > 2**ADDR_W -> overflow; POP of n words with
//   n > depth -> underflow. Rejected: go straight to DONE, rsp_err=1, no memory access, sp/depth
//   and rsp_rdata unchanged, matching sticky flag set.
//  Wrap: sp arithmetic is modulo 2**ADDR_W; capacity checks prevent wrap into live data.
//  err_clr with simultaneous new error: set wins. cmd_* ignored when cmd_ready=0.
// TESTING (ADDR_W=4, DATA_W=16)
//  Reset -> sp=4'hF, empty=1, cmd_ready=1, all strobes 0; reset asserted in WR_LO -> sp=F, IDLE.
//  PUSH32 32'hDEAD_BEEF -> mem[F]=DEAD, mem[E]=BEEF, sp=D, rsp_valid 3 cycles after accept.
//  Then POP32 -> reads E then F, rsp_rdata=32'hDEAD_BEEF 4 cycles after accept, sp=F, empty=1.
//  16x PUSH16 -> full=1, sp=F (wrapped); 17th PUSH16 -> rsp_err=1, ovf=1, no mem_we, sp unchanged.
//  Empty stack POP16 -> rsp_err=1, unf=1, rsp_rdata keeps prior value; err_clr -> unf=0.
//  One word on stack, POP32 -> underflow, depth stays 1; following POP16 returns that word.

Source files
------------

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - data-memory stack access sequencer (PUSH/POP 16/32-bit, full-descending SP)
module stack_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [2*DATA_W-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   sp,
  output logic                empty,
  output logic                full,
  output logic                ovf,
  output logic                unf,
  input  logic                err_clr
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_LO, RD_HI, CAP, DONE} state_t;

  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [ADDR_W:0]       depth;
  logic [2*DATA_W-1:0]   wdata_q;
  logic                  wide_q;
  logic [DATA_W-1:0]     lo_q;

  logic                  accept;
  logic                  is_push;
  logic [ADDR_W+1:0]     words;
  logic                  over;
  logic                  under;
  logic                  reject;

  // Accept-time decode and capacity checks; widths carry one extra bit so depth+2 cannot wrap.
  always_comb begin
    accept  = cmd_valid && cmd_ready;
    is_push = ~cmd_op[0];
    words   = cmd_op[1] ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1);
    over    = is_push  && (({1'b0, depth} + words) > {1'b0, CAPACITY});
    under   = !is_push && (words > {1'b0, depth});
    reject  = over || under;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic: rejected commands skip all memory phases and go straight to DONE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (reject)       next_state = DONE;
          else if (is_push) next_state = cmd_op[1] ? WR_HI : WR_LO;
          else              next_state = RD_LO;
        end
      end
      WR_HI:   next_state = WR_LO;
      WR_LO:   next_state = DONE;
      RD_LO:   next_state = wide_q ? RD_HI : CAP;
      RD_HI:   next_state = CAP;
      CAP:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; reads target sp+1, writes target sp.
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    mem_we    = (state == WR_HI) || (state == WR_LO);
    mem_re    = (state == RD_LO) || (state == RD_HI);
    mem_addr  = mem_re ? (sp + ONE) : sp;
    mem_wdata = (state == WR_HI) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
    empty     = (depth == '0);
    full      = (depth == CAPACITY);
  end

  // Stack pointer and depth move one word per memory access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp    <= '1;
      depth <= '0;
    end else if (mem_we) begin
      sp    <= sp - ONE;
      depth <= depth + 1'b1;
    end else if (mem_re) begin
      sp    <= sp + ONE;
      depth <= depth - 1'b1;
    end
  end

  // Command latch, response status and pop-data assembly (lo from RD_HI, hi from CAP).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_q   <= '0;
      wide_q    <= 1'b0;
      lo_q      <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wdata_q <= cmd_wdata;
        wide_q  <= cmd_op[1];
        rsp_err <= reject;
      end
      if (state == RD_HI) lo_q <= mem_rdata;
      if (state == CAP) begin
        rsp_rdata <= wide_q ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
      end
    end
  end

  // Sticky error flags; a new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (accept && over)  || (ovf && !err_clr);
      unf <= (accept && under) || (unf && !err_clr);
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - directed self-checking bench for stack_seq with a 16-word memory model
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [3:0]  sp;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;
  logic        err_clr;

  logic [15:0] mem [16];
  logic [3:0]  rd_log [64];
  int          rd_n = 0;
  int          wr_n = 0;
  int          vectors = 0;
  int          miscompares = 0;

  stack_seq #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .empty(empty), .full(full), .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Single-port memory model with one-cycle read latency, plus access logging.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_n <= wr_n + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      rd_log[rd_n % 64] <= mem_addr;
      rd_n <= rd_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from IDLE, measure accept-edge to rsp_valid sampling edge, end back in IDLE.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic clr);
    int k;
    cmd_op = op; cmd_wdata = wd; cmd_valid = 1'b1; err_clr = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0; err_clr = 1'b0;
    k = 0;
    while (!rsp_valid && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, k + 1, exp_lat);
    check({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    int r0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem_rdata = 16'h0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wdata = 32'h0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sp",        {28'b0, sp}, 32'hF);
    check("reset empty",     {31'b0, empty}, 32'h1);
    check("reset full",      {31'b0, full}, 32'h0);
    check("reset ready",     {31'b0, cmd_ready}, 32'h1);
    check("reset strobes",   {29'b0, mem_we, mem_re, rsp_valid}, 32'h0);
    check("reset rdata",     rsp_rdata, 32'h0);
    check("reset flags",     {29'b0, ovf, unf, rsp_err}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset while PUSH16 is in WR_LO aborts the sequence.
    cmd_op = 2'b00; cmd_wdata = 32'h5555; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("in WR_LO we", {31'b0, mem_we}, 32'h1);
    rst = 1'b0; #2; rst = 1'b1;
    @(posedge clk); #1;
    check("abort sp",    {28'b0, sp}, 32'hF);
    check("abort ready", {31'b0, cmd_ready}, 32'h1);
    check("abort empty", {31'b0, empty}, 32'h1);

    // PUSH32 then POP32 round trip.
    do_cmd("push32", 2'b10, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    check("push32 mem F", {16'b0, mem[15]}, 32'hDEAD);
    check("push32 mem E", {16'b0, mem[14]}, 32'hBEEF);
    check("push32 sp",    {28'b0, sp}, 32'hD);
    r0 = rd_n;
    do_cmd("pop32", 2'b11, 32'h0, 4, 1'b0, 1'b0);
    check("pop32 rdata",  rsp_rdata, 32'hDEAD_BEEF);
    check("pop32 reads",  rd_n - r0, 2);
    check("pop32 rd0",    {28'b0, rd_log[r0 % 64]}, 32'hE);
    check("pop32 rd1",    {28'b0, rd_log[(r0 + 1) % 64]}, 32'hF);
    check("pop32 sp",     {28'b0, sp}, 32'hF);
    check("pop32 empty",  {31'b0, empty}, 32'h1);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 16; i++) do_cmd("fill push16", 2'b00, 32'hABCD_1000 + i, 2, 1'b0, 1'b0);
    check("fill full", {31'b0, full}, 32'h1);
    check("fill sp",   {28'b0, sp}, 32'hF);
    check("fill mem0", {16'b0, mem[0]}, 32'h100F);
    w0 = wr_n;
    do_cmd("ovf push16", 2'b00, 32'h7777, 1, 1'b1, 1'b0);
    check("ovf flag",   {31'b0, ovf}, 32'h1);
    check("ovf no we",  wr_n - w0, 0);
    check("ovf sp",     {28'b0, sp}, 32'hF);
    check("ovf full",   {31'b0, full}, 32'h1);

    // Drain in LIFO order, POP16 zero-extends.
    for (int j = 0; j < 16; j++) begin
      do_cmd("drain pop16", 2'b01, 32'h0, 3, 1'b0, 1'b0);
      check("drain rdata", rsp_rdata, 32'h0000_100F - j);
    end
    check("drain empty", {31'b0, empty}, 32'h1);
    check("drain sp",    {28'b0, sp}, 32'hF);

    // Underflow on empty stack keeps prior rdata; err_clr clears both flags.
    r0 = rd_n;
    do_cmd("unf pop16", 2'b01, 32'h0, 1, 1'b1, 1'b0);
    check("unf flag",   {31'b0, unf}, 32'h1);
    check("unf rdata",  rsp_rdata, 32'h0000_1000);
    check("unf no re",  rd_n - r0, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr flags",  {30'b0, ovf, unf}, 32'h0);

    // One word on stack: POP32 underflows (err_clr on same edge loses), then POP16 gets the word.
    do_cmd("one push16", 2'b00, 32'hFFFF_00AB, 2, 1'b0, 1'b0);
    do_cmd("one pop32", 2'b11, 32'h0, 1, 1'b1, 1'b1);
    check("one unf set wins", {31'b0, unf}, 32'h1);
    check("one sp",     {28'b0, sp}, 32'hE);
    check("one empty",  {31'b0, empty}, 32'h0);
    do_cmd("one pop16", 2'b01, 32'h0, 3, 1'b0, 1'b0);
    check("one rdata",  rsp_rdata, 32'h0000_00AB);
    check("one final empty", {31'b0, empty}, 32'h1);
    check("one final sp",    {28'b0, sp}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
